dwpe_feeder: RTL and testbench

Upstream feeder for the depthwise PE array. Buffers one input tile of POY+K-1 rows × POX+K-1 pixels plus the K×K kernel weights, then replays the tile as K×K shifted POY×POX windows, one kernel tap per cycle. Each window goes out with its single broadcast weight and the array enable. The outputs connect directly to the array's `pixel_array`, `weight` and `dwpe_ena` inputs.

---
 rtl/dw_pkg.sv | 19 +
 rtl/dwpe_feeder_if.sv | 28 ++
 rtl/dw_tile_buf.sv | 42 ++++
 rtl/dwpe_feeder.sv | 158 +++++++++++++++
 tb/tb_dwpe_feeder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dw_pkg.sv
// Shared types and sizing helpers for the depthwise PE feeder.
package dw_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      ISSUE = 1'b1
   } feed_state_t;

   localparam int DEF_K = 3;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int tap_w(input int k);
      return idx_w(k * k);
   endfunction

endpackage

// File: rtl/dwpe_feeder_if.sv
// Tile-in / window-out bundle between the row source, the feeder and the depthwise PE array.
interface dwpe_feeder_if import dw_pkg::*; #(
   parameter int DW  = 32,
   parameter int POX = 16,
   parameter int POY = 3,
   parameter int K   = DEF_K
);
   logic          row_valid;
   logic          row_ready;
   logic [DW-1:0] row_data    [POX+K-1];
   logic [DW-1:0] wgt_data    [K*K];
   logic          stall;
   logic [DW-1:0] pixel_array [POY][POX];
   logic [DW-1:0] weight;
   logic          dwpe_ena;
   logic          tap_first;
   logic          tap_last;

   modport master (
      output row_valid, row_data, wgt_data, stall,
      input  row_ready, pixel_array, weight, dwpe_ena, tap_first, tap_last
   );

   modport slave (
      input  row_valid, row_data, wgt_data, stall,
      output row_ready, pixel_array, weight, dwpe_ena, tap_first, tap_last
   );
endinterface

// File: rtl/dw_tile_buf.sv
// Tile storage: one row written per cycle, combinational POY x POX window at offset (ky,kx).
// Window select is pure mux; contents are only written while the feeder is loading.
module dw_tile_buf import dw_pkg::*; #(
   parameter  int DW   = 32,
   parameter  int POX  = 16,
   parameter  int POY  = 3,
   parameter  int K    = DEF_K,
   localparam int ROWS = POY + K - 1,
   localparam int COLS = POX + K - 1,
   localparam int RW   = idx_w(ROWS),
   localparam int CW   = idx_w(COLS),
   localparam int KW   = idx_w(K)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [RW-1:0] i_wr_row,
   input  logic [DW-1:0] i_wr_data [COLS],
   input  logic [KW-1:0] i_ky,
   input  logic [KW-1:0] i_kx,
   output logic [DW-1:0] o_win     [POY][POX]
);

   logic [DW-1:0] r_buf [ROWS][COLS];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int c = 0; c < COLS; c++) begin
            r_buf[i_wr_row][c] <= i_wr_data[c];
         end
      end
   end

   // Row/column sums never exceed ROWS-1 / COLS-1 because ky,kx < K.
   always_comb begin
      for (int i = 0; i < POY; i++) begin
         for (int j = 0; j < POX; j++) begin
            o_win[i][j] = r_buf[RW'(i) + RW'(i_ky)][CW'(j) + CW'(i_kx)];
         end
      end
   end

endmodule

// File: rtl/dwpe_feeder.sv
// Loads a (POY+K-1)-row tile plus K*K weights, then replays K*K shifted windows, one tap per cycle.
// Tap 0 registered one cycle after the last row beat; stall freezes tap issue; row_ready low during issue.
module dwpe_feeder import dw_pkg::*; #(
   parameter int DW  = 32,
   parameter int POX = 16,
   parameter int POY = 3,
   parameter int K   = DEF_K
) (
   input  logic         clk,
   input  logic         rst,
   dwpe_feeder_if.slave fd
);

   localparam int ROWS = POY + K - 1;
   localparam int KK   = K * K;
   localparam int RW   = idx_w(ROWS);
   localparam int TW   = tap_w(K);
   localparam int KW   = idx_w(K);

   feed_state_t   r_state;
   feed_state_t   w_state_nxt;
   logic [RW-1:0] r_row_cnt;
   logic [TW-1:0] r_tap;
   logic [KW-1:0] r_ky;
   logic [KW-1:0] r_kx;
   logic [DW-1:0] r_wgt    [KK];
   logic [DW-1:0] r_pix    [POY][POX];
   logic [DW-1:0] r_weight;
   logic          r_ena;
   logic          r_first;
   logic          r_last;

   logic          w_row_ready;
   logic          w_accept;
   logic          w_row_last;
   logic          w_tap_last;
   logic          w_issue_go;
   logic [DW-1:0] w_win    [POY][POX];

   assign w_row_last = (r_row_cnt == RW'(ROWS - 1));
   assign w_tap_last = (r_tap == TW'(KK - 1));
   assign w_accept   = fd.row_valid && w_row_ready;
   assign w_issue_go = (r_state == ISSUE) && !fd.stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_ready = 1'b0;
      case (r_state)
         LOAD: begin
            w_row_ready = 1'b1;
            if (fd.row_valid && w_row_last) begin
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!fd.stall && w_tap_last) begin
               w_state_nxt = LOAD;
            end
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   // ky/kx run alongside tap so the window select needs no divider.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_cnt <= '0;
         r_tap     <= '0;
         r_ky      <= '0;
         r_kx      <= '0;
      end else begin
         if (w_accept) begin
            r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
         end
         if (w_accept && w_row_last) begin
            r_tap <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
         end else if (w_issue_go) begin
            r_tap <= w_tap_last ? '0 : r_tap + TW'(1);
            if (r_kx == KW'(K - 1)) begin
               r_kx <= '0;
               r_ky <= (r_ky == KW'(K - 1)) ? '0 : r_ky + KW'(1);
            end else begin
               r_kx <= r_kx + KW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept && (r_row_cnt == '0)) begin
         for (int n = 0; n < KK; n++) begin
            r_wgt[n] <= fd.wgt_data[n];
         end
      end
   end

   dw_tile_buf #(
      .DW  (DW),
      .POX (POX),
      .POY (POY),
      .K   (K)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (w_accept),
      .i_wr_row  (r_row_cnt),
      .i_wr_data (fd.row_data),
      .i_ky      (r_ky),
      .i_kx      (r_kx),
      .o_win     (w_win)
   );

   // Stalled cycles drop the strobes but keep window and weight on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < POY; i++) begin
            for (int j = 0; j < POX; j++) begin
               r_pix[i][j] <= '0;
            end
         end
         r_weight <= '0;
         r_ena    <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
      end else if (w_issue_go) begin
         for (int i = 0; i < POY; i++) begin
            for (int j = 0; j < POX; j++) begin
               r_pix[i][j] <= w_win[i][j];
            end
         end
         r_weight <= r_wgt[r_tap];
         r_ena    <= 1'b1;
         r_first  <= (r_tap == '0);
         r_last   <= w_tap_last;
      end else begin
         r_ena    <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
      end
   end

   assign fd.row_ready   = w_row_ready;
   assign fd.pixel_array = r_pix;
   assign fd.weight      = r_weight;
   assign fd.dwpe_ena    = r_ena;
   assign fd.tap_first   = r_first;
   assign fd.tap_last    = r_last;

endmodule

// File: tb/tb_dwpe_feeder.sv
// Scoreboard bench for dwpe_feeder: default geometry plus a POX=4/POY=1/K=5 variant.
module tb_dwpe_feeder;
   import dw_pkg::*;

   localparam int DW = 32, POX = 16, POY = 3, K = 3, ROWS = 5, COLS = 18, KK = 9;
   localparam int POX2 = 4, POY2 = 1, K2 = 5, ROWS2 = 5, COLS2 = 8, KK2 = 25;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dwpe_feeder_if #(.DW(DW), .POX(POX),  .POY(POY),  .K(K))  bus  ();
   dwpe_feeder_if #(.DW(DW), .POX(POX2), .POY(POY2), .K(K2)) bus2 ();

   dwpe_feeder #(.DW(DW), .POX(POX),  .POY(POY),  .K(K))  dut  (.clk(clk), .rst(rst), .fd(bus));
   dwpe_feeder #(.DW(DW), .POX(POX2), .POY(POY2), .K(K2)) dut2 (.clk(clk), .rst(rst), .fd(bus2));

   typedef struct {
      int          cyc;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] w;
      logic        first;
      logic        last;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   gq[$];

   function automatic logic [31:0] pix(input int base, input int r, input int c);
      return 32'(base + r * 32 + c);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor for the default-geometry feeder
   exp_t e1, last1;
   bit   in_tile1 = 1'b0;
   int   low_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
         gq.delete();
         in_tile1 = 1'b0;
         low_cnt  = 0;
      end else begin
         if (bus.dwpe_ena) begin
            if (q1.size() == 0) begin
               check("unexpected_ena", 32'd1, 32'd0);
            end else begin
               e1 = q1.pop_front();
               check("tap_cycle", cyc, e1.cyc);
               check("pix_0_0",   bus.pixel_array[0][0], e1.p0);
               check("pix_1_5",   bus.pixel_array[1][5], e1.p1);
               check("pix_2_15",  bus.pixel_array[2][15], e1.p2);
               check("weight",    bus.weight, e1.w);
               check("tap_first", bus.tap_first, e1.first);
               check("tap_last",  bus.tap_last, e1.last);
               last1    = e1;
               in_tile1 = !e1.last;
            end
         end else if (!bus.row_ready && in_tile1) begin
            check("hold_pix_0_0", bus.pixel_array[0][0], last1.p0);
            check("hold_weight",  bus.weight, last1.w);
            check("stall_first",  bus.tap_first, 1'b0);
            check("stall_last",   bus.tap_last, 1'b0);
         end
         if (!bus.row_ready) begin
            low_cnt++;
         end else if (low_cnt > 0) begin
            if (gq.size() == 0) check("unexpected_issue", low_cnt, 0);
            else check("issue_len", low_cnt, gq.pop_front());
            low_cnt = 0;
         end
      end
   end

   // Monitor for the variant feeder
   exp_t e2;
   always @(negedge clk) begin
      if (rst) begin
         q2.delete();
      end else if (bus2.dwpe_ena) begin
         if (q2.size() == 0) begin
            check("v_unexpected_ena", 32'd1, 32'd0);
         end else begin
            e2 = q2.pop_front();
            check("v_tap_cycle", cyc, e2.cyc);
            check("v_pix_0_0",   bus2.pixel_array[0][0], e2.p0);
            check("v_pix_0_3",   bus2.pixel_array[0][3], e2.p1);
            check("v_weight",    bus2.weight, e2.w);
            check("v_tap_first", bus2.tap_first, e2.first);
            check("v_tap_last",  bus2.tap_last, e2.last);
         end
      end
   end

   task automatic run_tile(input int base, input int wb, input bit toggle,
                           input bit [KK-1:0] stl, input bit keep, input int abort_at);
      int r = 0, beat = 0, n = 0, sc = 0, nst = 0;
      bit acc, s;
      exp_t e;
      while (r < ROWS) begin
         bus.row_valid = !(toggle && (beat % 2 == 1));
         for (int c = 0; c < COLS; c++) bus.row_data[c] = pix(base, r, c);
         for (int m = 0; m < KK; m++) bus.wgt_data[m] = (r == 0) ? 32'(wb + m) : 32'(999 + r * 10 + m);
         acc = bus.row_valid && bus.row_ready;
         @(posedge clk); #1;
         if (acc) r++;
         beat++;
         if (beat > 50) begin
            check("load_timeout", beat, 0);
            bus.row_valid = 1'b0;
            return;
         end
      end
      if (!keep) begin
         bus.row_valid = 1'b0;
      end else begin
         for (int c = 0; c < COLS; c++) bus.row_data[c] = pix(base + 5000, 0, c);
         for (int m = 0; m < KK; m++) bus.wgt_data[m] = 32'd777;
      end
      while (n < KK) begin
         if (n == abort_at) begin
            @(negedge clk); #1;
            rst = 1'b1;
            #1;
            check("rst_ena",      bus.dwpe_ena, 1'b0);
            check("rst_first",    bus.tap_first, 1'b0);
            check("rst_last",     bus.tap_last, 1'b0);
            check("rst_weight",   bus.weight, 32'd0);
            check("rst_pix_0_0",  bus.pixel_array[0][0], 32'd0);
            check("rst_pix_2_15", bus.pixel_array[2][15], 32'd0);
            check("rst_ready",    bus.row_ready, 1'b1);
            @(posedge clk); @(negedge clk); @(posedge clk); #1;
            rst = 1'b0;
            bus.stall = 1'b0;
            return;
         end
         s = stl[n] && (sc < 2);
         bus.stall = s;
         if (!s) begin
            e.cyc   = cyc + 1;
            e.p0    = pix(base, n / K, n % K);
            e.p1    = pix(base, 1 + n / K, 5 + n % K);
            e.p2    = pix(base, POY - 1 + n / K, POX - 1 + n % K);
            e.w     = 32'(wb + n);
            e.first = (n == 0);
            e.last  = (n == KK - 1);
            q1.push_back(e);
         end
         @(posedge clk); #1;
         if (s) begin
            sc++;
            nst++;
         end else begin
            n++;
            sc = 0;
         end
      end
      bus.stall = 1'b0;
      gq.push_back(KK + nst);
   endtask

   task automatic run_tile2(input int base, input int wb);
      exp_t e;
      for (int r = 0; r < ROWS2; r++) begin
         bus2.row_valid = 1'b1;
         for (int c = 0; c < COLS2; c++) bus2.row_data[c] = pix(base, r, c);
         for (int m = 0; m < KK2; m++) bus2.wgt_data[m] = (r == 0) ? 32'(wb + m) : 32'd555;
         check("v_row_ready", bus2.row_ready, 1'b1);
         @(posedge clk); #1;
      end
      bus2.row_valid = 1'b0;
      for (int n = 0; n < KK2; n++) begin
         e.cyc   = cyc + 1;
         e.p0    = pix(base, n / K2, n % K2);
         e.p1    = pix(base, n / K2, 3 + n % K2);
         e.p2    = 32'd0;
         e.w     = 32'(wb + n);
         e.first = (n == 0);
         e.last  = (n == KK2 - 1);
         q2.push_back(e);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: reached time %0t without finishing", $time);
      $fatal(1);
   end

   initial begin
      bus.row_valid  = 1'b0;
      bus.stall      = 1'b0;
      bus2.row_valid = 1'b0;
      bus2.stall     = 1'b0;
      for (int c = 0; c < COLS; c++)  bus.row_data[c]  = '0;
      for (int m = 0; m < KK; m++)    bus.wgt_data[m]  = '0;
      for (int c = 0; c < COLS2; c++) bus2.row_data[c] = '0;
      for (int m = 0; m < KK2; m++)   bus2.wgt_data[m] = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ena",      bus.dwpe_ena, 1'b0);
      check("reset_first",    bus.tap_first, 1'b0);
      check("reset_last",     bus.tap_last, 1'b0);
      check("reset_weight",   bus.weight, 32'd0);
      check("reset_pix_2_15", bus.pixel_array[2][15], 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_release", bus.row_ready, 1'b1);

      run_tile(0, 100, 1'b0, '0, 1'b0, KK);
      run_tile(0, 100, 1'b0, 9'h084, 1'b0, KK);
      run_tile(0, 100, 1'b0, '0, 1'b1, KK);
      run_tile(1000, 200, 1'b0, '0, 1'b1, KK);
      bus.row_valid = 1'b0;
      run_tile(64, 300, 1'b1, '0, 1'b0, KK);
      run_tile(0, 100, 1'b0, '0, 1'b0, 5);
      check("ready_after_abort", bus.row_ready, 1'b1);
      run_tile(2000, 400, 1'b0, '0, 1'b0, KK);
      run_tile2(0, 100);

      repeat (4) @(posedge clk);
      #1;
      check("q1_drained",  q1.size(), 0);
      check("q2_drained",  q2.size(), 0);
      check("gap_drained", gq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
